ysyx_23060124_wbu: RTL

Write-back and next-PC unit, directly downstream of the execute unit. Captures one executed instruction per handshake, commits its register-file and CSR writes, and computes the next PC. It then offers that PC to the fetch unit through a valid/ready handshake. It also generates the ecall trap writes (mepc, mcause) over two commit cycles.

---
 rtl/ysyx_23060124_wbu_pkg.sv | 17 +
 rtl/ysyx_23060124_npc_gen.sv | 40 ++++
 rtl/ysyx_23060124_wbu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060124_wbu_pkg.sv
// Shared definitions for the write-back unit: FSM state encodings, trap CSR
// addresses and the machine-mode ecall cause code.
package ysyx_23060124_wbu_pkg;

    typedef enum logic [2:0] {
        ysyx_23060124_WBU_BOOT   = 3'd0,
        ysyx_23060124_WBU_IDLE   = 3'd1,
        ysyx_23060124_WBU_COMMIT = 3'd2,
        ysyx_23060124_WBU_TRAP   = 3'd3,
        ysyx_23060124_WBU_HAND   = 3'd4
    } wbu_state_e;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam int unsigned ECALL_M    = 11;

endpackage

// File: rtl/ysyx_23060124_npc_gen.sv
// Combinational next-PC selector. The control-flow class inputs are one-hot
// or all zero; all zero falls through to the sequential pc+4.
module ysyx_23060124_npc_gen #(
    parameter int ISA_WIDTH = 32
) (
    input  logic [ISA_WIDTH-1:0] i_pc,
    input  logic [ISA_WIDTH-1:0] i_imm,
    input  logic [ISA_WIDTH-1:0] i_src1,
    input  logic [ISA_WIDTH-1:0] i_mtvec,
    input  logic [ISA_WIDTH-1:0] i_mepc,
    input  logic                 i_taken,
    input  logic                 i_brch,
    input  logic                 i_jal,
    input  logic                 i_jalr,
    input  logic                 i_ecall,
    input  logic                 i_mret,
    output logic [ISA_WIDTH-1:0] o_npc
);

    logic [ISA_WIDTH-1:0] seq_pc;
    logic [ISA_WIDTH-1:0] rel_pc;

    always_comb begin
        seq_pc = i_pc + ISA_WIDTH'(4);
        rel_pc = i_pc + i_imm;
        o_npc  = seq_pc;
        if (i_brch) begin
            o_npc = i_taken ? rel_pc : seq_pc;
        end else if (i_jal) begin
            o_npc = rel_pc;
        end else if (i_jalr) begin
            o_npc = (i_src1 + i_imm) & ~ISA_WIDTH'(1);
        end else if (i_ecall) begin
            o_npc = i_mtvec;
        end else if (i_mret) begin
            o_npc = i_mepc;
        end
    end

endmodule

// File: rtl/ysyx_23060124_wbu.sv
// Write-back and next-PC unit: latches one executed instruction, commits its
// rd/CSR writes (plus the two-cycle ecall trap writes) and offers the next PC
// to fetch. Defining YSYX_23060124_WBU_INSTRET_EN adds a 64-bit retire counter.
module ysyx_23060124_wbu
    import ysyx_23060124_wbu_pkg::*;
#(
    parameter int                   ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0] RST_PC    = ISA_WIDTH'(32'h8000_0000)
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    input  logic [ISA_WIDTH-1:0] i_res,
    input  logic [ISA_WIDTH-1:0] i_pc,
    input  logic [ISA_WIDTH-1:0] i_imm,
    input  logic [ISA_WIDTH-1:0] i_src1,
    input  logic [4:0]           i_rd,
    input  logic                 i_rd_wen,
    input  logic                 i_brch,
    input  logic                 i_jal,
    input  logic                 i_jalr,
    input  logic                 i_ecall,
    input  logic                 i_mret,
    input  logic                 i_csr_wen,
    input  logic [11:0]          i_csr_addr,
    input  logic [ISA_WIDTH-1:0] i_csr_rdata,
    input  logic [ISA_WIDTH-1:0] i_mtvec,
    input  logic [ISA_WIDTH-1:0] i_mepc,
    output logic                 o_rd_wen,
    output logic [4:0]           o_rd_waddr,
    output logic [ISA_WIDTH-1:0] o_rd_wdata,
    output logic                 o_csr_wen,
    output logic [11:0]          o_csr_waddr,
    output logic [ISA_WIDTH-1:0] o_csr_wdata,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
`ifdef YSYX_23060124_WBU_INSTRET_EN
    output logic [63:0]          o_instret,
`endif
    output logic [ISA_WIDTH-1:0] o_next_pc
);

    typedef struct packed {
        logic [ISA_WIDTH-1:0] res;
        logic [ISA_WIDTH-1:0] pc;
        logic [ISA_WIDTH-1:0] imm;
        logic [ISA_WIDTH-1:0] src1;
        logic [ISA_WIDTH-1:0] csr_rdata;
        logic [ISA_WIDTH-1:0] mtvec;
        logic [ISA_WIDTH-1:0] mepc;
        logic [4:0]           rd;
        logic                 rd_wen;
        logic                 brch;
        logic                 jal;
        logic                 jalr;
        logic                 ecall;
        logic                 mret;
        logic                 csr_wen;
        logic [11:0]          csr_addr;
    } instr_t;

    wbu_state_e           state_q, state_d;
    instr_t               instr_q, instr_d;
    logic                 capture;
    logic [ISA_WIDTH-1:0] npc;

    assign capture = (state_q == ysyx_23060124_WBU_IDLE) && i_pre_valid;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ysyx_23060124_WBU_BOOT;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        instr_d = instr_q;
        if (capture) begin
            instr_d.res       = i_res;
            instr_d.pc        = i_pc;
            instr_d.imm       = i_imm;
            instr_d.src1      = i_src1;
            instr_d.csr_rdata = i_csr_rdata;
            instr_d.mtvec     = i_mtvec;
            instr_d.mepc      = i_mepc;
            instr_d.rd        = i_rd;
            instr_d.rd_wen    = i_rd_wen;
            instr_d.brch      = i_brch;
            instr_d.jal       = i_jal;
            instr_d.jalr      = i_jalr;
            instr_d.ecall     = i_ecall;
            instr_d.mret      = i_mret;
            instr_d.csr_wen   = i_csr_wen;
            instr_d.csr_addr  = i_csr_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ysyx_23060124_WBU_BOOT:   if (i_post_ready) state_d = ysyx_23060124_WBU_IDLE;
            ysyx_23060124_WBU_IDLE:   if (i_pre_valid)  state_d = ysyx_23060124_WBU_COMMIT;
            ysyx_23060124_WBU_COMMIT: state_d = instr_q.ecall ? ysyx_23060124_WBU_TRAP
                                                              : ysyx_23060124_WBU_HAND;
            ysyx_23060124_WBU_TRAP:   state_d = ysyx_23060124_WBU_HAND;
            ysyx_23060124_WBU_HAND:   if (i_post_ready) state_d = ysyx_23060124_WBU_IDLE;
            default:                  state_d = ysyx_23060124_WBU_BOOT;
        endcase
    end

    ysyx_23060124_npc_gen #(
        .ISA_WIDTH (ISA_WIDTH)
    ) u_npc_gen (
        .i_pc    (instr_q.pc),
        .i_imm   (instr_q.imm),
        .i_src1  (instr_q.src1),
        .i_mtvec (instr_q.mtvec),
        .i_mepc  (instr_q.mepc),
        .i_taken (instr_q.res[0]),
        .i_brch  (instr_q.brch),
        .i_jal   (instr_q.jal),
        .i_jalr  (instr_q.jalr),
        .i_ecall (instr_q.ecall),
        .i_mret  (instr_q.mret),
        .o_npc   (npc)
    );

    // Write ports read back as zero outside the commit/trap cycles.
    always_comb begin
        o_pre_ready  = 1'b0;
        o_post_valid = 1'b0;
        o_next_pc    = npc;
        o_rd_wen     = 1'b0;
        o_rd_waddr   = '0;
        o_rd_wdata   = '0;
        o_csr_wen    = 1'b0;
        o_csr_waddr  = '0;
        o_csr_wdata  = '0;
        unique case (state_q)
            ysyx_23060124_WBU_BOOT: begin
                o_post_valid = 1'b1;
                o_next_pc    = RST_PC;
            end
            ysyx_23060124_WBU_IDLE: o_pre_ready = 1'b1;
            ysyx_23060124_WBU_COMMIT: begin
                o_rd_wen   = instr_q.rd_wen & (|instr_q.rd);
                o_rd_waddr = instr_q.rd;
                o_rd_wdata = instr_q.csr_wen ? instr_q.csr_rdata : instr_q.res;
                if (instr_q.ecall) begin
                    o_csr_wen   = 1'b1;
                    o_csr_waddr = CSR_MEPC;
                    o_csr_wdata = instr_q.pc;
                end else if (instr_q.csr_wen) begin
                    o_csr_wen   = 1'b1;
                    o_csr_waddr = instr_q.csr_addr;
                    o_csr_wdata = instr_q.res;
                end
            end
            ysyx_23060124_WBU_TRAP: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MCAUSE;
                o_csr_wdata = ISA_WIDTH'(ECALL_M);
            end
            ysyx_23060124_WBU_HAND: o_post_valid = 1'b1;
            default: ;
        endcase
    end

`ifdef YSYX_23060124_WBU_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if ((state_q == ysyx_23060124_WBU_HAND) && i_post_ready) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) instret_q <= '0;
        else          instret_q <= instret_d;
    end

    assign o_instret = instret_q;
`endif

endmodule
